// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexed 4-digit common-anode 7-segment driver.
// Digits are double-buffered (pending -> display at frame boundary) so a
// frame never mixes old and new values. Optional leading-zero blanking.
module bcd_seg_scanner #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] thousand_i,
  input  logic [3:0] hundreds_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  input  logic       blank_lz_i,
  input  logic [3:0] dp_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       busy_o,
  output logic       frame_o
);

  localparam int unsigned DIG_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NDIG   = 4;
  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [NDIG-1:0]  AN_OFF  = '1;
  localparam logic [SEG_W-1:0] SEG_OFF = '1;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;

  // Four BCD digits, d3 = leftmost
  typedef struct packed {
    logic [DIG_W-1:0] d3;
    logic [DIG_W-1:0] d2;
    logic [DIG_W-1:0] d1;
    logic [DIG_W-1:0] d0;
  } digits_t;

  // Scan position: which digit is currently being driven
  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_state_t;

  scan_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic             boundary_c;

  digits_t          disp_q;
  digits_t          pend_q;
  logic             pend_valid_q;
  digits_t          in_digits_c;

  logic [1:0]       idx_c;
  logic [DIG_W-1:0] cur_digit_c;
  logic             cur_blank_c;
  logic             blank3_c, blank2_c, blank1_c;

  logic [NDIG-1:0]  an_q;
  logic [SEG_W-1:0] seg_q;
  logic             dp_q;
  logic             frame_q;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign in_digits_c = '{d3: thousand_i, d2: hundreds_i, d1: tens_i, d0: ones_i};

  assign tick_c = (div_q == DIV_LAST);
  assign idx_c  = state_q;

  // Per-digit dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN_D0;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan next-state: advance one digit per tick, wrap 3 -> 0 marks a frame boundary
  always_comb begin
    state_d    = state_q;
    boundary_c = 1'b0;
    if (tick_c) begin
      case (state_q)
        SCAN_D0: state_d = SCAN_D1;
        SCAN_D1: state_d = SCAN_D2;
        SCAN_D2: state_d = SCAN_D3;
        SCAN_D3: begin
          state_d    = SCAN_D0;
          boundary_c = 1'b1;
        end
        default: state_d = SCAN_D0;
      endcase
    end
  end

  // Double buffer: loads park in pending, commit to display only on a boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else if (boundary_c) begin
      if (load_i) begin
        disp_q       <= in_digits_c;
        pend_valid_q <= 1'b0;
      end else if (pend_valid_q) begin
        disp_q       <= pend_q;
        pend_valid_q <= 1'b0;
      end
    end else if (load_i) begin
      pend_q       <= in_digits_c;
      pend_valid_q <= 1'b1;
    end
  end

  // Leading-zero blanking chain from the leftmost digit; digit 0 always shown
  assign blank3_c = blank_lz_i && (disp_q.d3 == '0);
  assign blank2_c = blank3_c && (disp_q.d2 == '0);
  assign blank1_c = blank2_c && (disp_q.d1 == '0);

  // Select the digit and blank flag for the current scan slot
  always_comb begin
    cur_digit_c = disp_q.d0;
    cur_blank_c = 1'b0;
    case (state_q)
      SCAN_D0: begin
        cur_digit_c = disp_q.d0;
        cur_blank_c = 1'b0;
      end
      SCAN_D1: begin
        cur_digit_c = disp_q.d1;
        cur_blank_c = blank1_c;
      end
      SCAN_D2: begin
        cur_digit_c = disp_q.d2;
        cur_blank_c = blank2_c;
      end
      SCAN_D3: begin
        cur_digit_c = disp_q.d3;
        cur_blank_c = blank3_c;
      end
      default: begin
        cur_digit_c = disp_q.d0;
        cur_blank_c = 1'b0;
      end
    endcase
  end

  // Registered display drive; single register stage keeps anodes glitch/overlap free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= cur_blank_c ? AN_OFF : ~(NDIG'(1) << idx_c);
      seg_q   <= seg_decode(cur_digit_c);
      dp_q    <= ~(dp_i[idx_c] & ~cur_blank_c);
      frame_q <= boundary_c;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign busy_o  = pend_valid_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner with a 4-cycle dwell per digit.
module tb_bcd_seg_scanner;

  logic       clk;
  logic       rst_n;
  logic       load_i;
  logic [3:0] thousand_i, hundreds_i, tens_i, ones_i;
  logic       blank_lz_i;
  logic [3:0] dp_i;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;
  logic       busy_o;
  logic       frame_o;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seg_scanner #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_i),
    .thousand_i (thousand_i),
    .hundreds_i (hundreds_i),
    .tens_i     (tens_i),
    .ones_i     (ones_i),
    .blank_lz_i (blank_lz_i),
    .dp_i       (dp_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .busy_o     (busy_o),
    .frame_o    (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: digits, controls, and expected an/seg/dp per scan slot (index 0 = digit 0)
  typedef struct packed {
    logic [3:0]       d3, d2, d1, d0;
    logic             blank;
    logic [3:0]       dp;
    logic [3:0][3:0]  an;
    logic [3:0][6:0]  seg;
    logic [3:0]       dpo;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0,
                              input logic blank, input logic [3:0] dp,
                              input logic [15:0] an, input logic [27:0] seg,
                              input logic [3:0] dpo);
    vec_t v;
    v.d3 = d3; v.d2 = d2; v.d1 = d1; v.d0 = d0;
    v.blank = blank; v.dp = dp;
    v.an = an; v.seg = seg; v.dpo = dpo;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_frame(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      seen = frame_o;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: frame_o not seen within 64 cycles", nm);
    end
  endtask

  task automatic load_digits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
    thousand_i = d3; hundreds_i = d2; tens_i = d1; ones_i = d0;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; load_i = 1'b0;
    thousand_i = '0; hundreds_i = '0; tens_i = '0; ones_i = '0;
    blank_lz_i = 1'b0; dp_i = '0;

    //               d3 d2 d1 d0 blz  dp       an(3..0)  seg(3..0)                              dpo
    vecs[0] = mk(1, 2, 3, 4, 0, 4'b0000, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
    vecs[1] = mk(0, 0, 0, 7, 1, 4'b0000, 16'hFFFE, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1111);
    vecs[2] = mk(0, 0, 0, 0, 1, 4'b0000, 16'hFFFE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    vecs[3] = mk(9, 8, 4'hC, 5, 0, 4'b0010, 16'h7BDE, {7'h10, 7'h00, 7'h3F, 7'h12}, 4'b1101);
    vecs[4] = mk(0, 5, 0, 0, 1, 4'b1111, 16'hFBDE, {7'h40, 7'h12, 7'h40, 7'h40}, 4'b1000);
    vecs[5] = mk(0, 0, 0, 0, 0, 4'b1000, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0111);

    // Asynchronous reset takes effect before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst an",    8'(an_o),    8'h0F);
    chk("rst seg",   8'(seg_o),   8'h7F);
    chk("rst dp",    8'(dp_o),    8'h01);
    chk("rst busy",  8'(busy_o),  8'h00);
    chk("rst frame", 8'(frame_o), 8'h00);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Table: load at start of a frame, commit on next boundary, check every slot
    for (int i = 0; i < 6; i++) begin
      wait_frame($sformatf("v%0d sync", i));
      blank_lz_i = vecs[i].blank;
      dp_i       = vecs[i].dp;
      load_digits(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
      chk($sformatf("v%0d busy pending", i), 8'(busy_o), 8'h01);
      wait_frame($sformatf("v%0d commit", i));
      chk($sformatf("v%0d busy cleared", i), 8'(busy_o), 8'h00);
      for (int k = 0; k < 4; k++) begin
        if (k == 0) step(); else repeat (4) step();
        if (k == 0) chk($sformatf("v%0d frame width", i), 8'(frame_o), 8'h00);
        chk($sformatf("v%0d slot%0d an", i, k),  8'(an_o),  8'(vecs[i].an[k]));
        chk($sformatf("v%0d slot%0d seg", i, k), 8'(seg_o), 8'(vecs[i].seg[k]));
        chk($sformatf("v%0d slot%0d dp", i, k),  8'(dp_o),  8'(vecs[i].dpo[k]));
      end
    end

    // Two loads mid-frame: last wins, old display held until boundary
    wait_frame("dbl sync");
    blank_lz_i = 1'b0; dp_i = '0;
    load_digits(5, 5, 5, 5);
    chk("dbl busy1", 8'(busy_o), 8'h01);
    repeat (3) step();
    load_digits(6, 6, 6, 6);
    chk("dbl busy2", 8'(busy_o), 8'h01);
    repeat (4) step();
    chk("dbl old an",  8'(an_o),  8'h0B);
    chk("dbl old seg", 8'(seg_o), 8'h40);
    wait_frame("dbl commit");
    chk("dbl busy clr", 8'(busy_o), 8'h00);
    step();
    chk("dbl new an",  8'(an_o),  8'h0E);
    chk("dbl new seg", 8'(seg_o), 8'h02);

    // Load on the boundary cycle goes straight to display, busy never rises
    repeat (14) step();
    chk("bnd busy pre", 8'(busy_o), 8'h00);
    load_digits(7, 7, 7, 7);
    chk("bnd frame", 8'(frame_o), 8'h01);
    chk("bnd busy",  8'(busy_o),  8'h00);
    step();
    chk("bnd busy post", 8'(busy_o), 8'h00);
    chk("bnd an",  8'(an_o),  8'h0E);
    chk("bnd seg", 8'(seg_o), 8'h78);

    // Reset pulse mid-frame while digit 2 is lit
    wait_frame("mrst sync");
    load_digits(3, 3, 3, 3);
    chk("mrst busy", 8'(busy_o), 8'h01);
    repeat (8) step();
    chk("mrst pre an",  8'(an_o),  8'h0B);
    chk("mrst pre seg", 8'(seg_o), 8'h78);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst an",    8'(an_o),    8'h0F);
    chk("mrst seg",   8'(seg_o),   8'h7F);
    chk("mrst dp",    8'(dp_o),    8'h01);
    chk("mrst busy0", 8'(busy_o),  8'h00);
    chk("mrst frame", 8'(frame_o), 8'h00);
    #3 rst_n = 1'b1;
    step();
    chk("mrst post an0",  8'(an_o),  8'h0E);
    chk("mrst post seg0", 8'(seg_o), 8'h40);
    repeat (4) step();
    chk("mrst post an1",  8'(an_o),  8'h0D);
    chk("mrst post seg1", 8'(seg_o), 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
